// File: rtl/codec_cfg_sequencer_if.sv
// codec_cfg_sequencer_if: I2C write-request handshake between the config sequencer and the I2C master
interface codec_cfg_sequencer_if;
  logic        i2c_start;
  logic [6:0]  i2c_dev;
  logic [15:0] i2c_addr;
  logic [7:0]  i2c_data;
  logic        i2c_busy;
  logic        i2c_done;
  logic        i2c_nack;
  modport master (output i2c_start, i2c_dev, i2c_addr, i2c_data, input i2c_busy, i2c_done, i2c_nack);
  modport slave (input i2c_start, i2c_dev, i2c_addr, i2c_data, output i2c_busy, i2c_done, i2c_nack);
endinterface

// File: rtl/codec_cfg_sequencer.sv
// codec_cfg_sequencer: walks a register table after power-up and writes each entry over I2C; CODEC_CFG_RETRY_EN enables NACK retries
module codec_cfg_sequencer #(
  parameter int         NUM_REGS = 16,
  parameter logic [6:0] DEV_ADDR = 7'h3B,
  parameter int         PWR_WAIT = 1024,
  parameter int         TIMEOUT  = 65535
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_start,
  output logic [7:0]            tbl_idx,
  input  logic [23:0]           tbl_entry,
  codec_cfg_sequencer_if.master i2c,
  output logic                  busy,
  output logic                  cfg_done,
  output logic                  error,
  output logic [1:0]            retry_cnt
);
  typedef enum logic [2:0] {WAIT_PWR, FETCH, ISSUE, WAIT_DONE, NEXT, DONE, ERROR} state_t;
  state_t      state, state_n;
  logic [7:0]  idx_n;
  logic [1:0]  retry_q, retry_n;
  logic [31:0] pwr_cnt, pwr_n, to_cnt, to_n;
  logic [15:0] addr_q, addr_n;
  logic [7:0]  data_q, data_n;
  logic        ph, ph_n;
  // next-state and datapath updates; timeout is tested before i2c_done so it wins a tie
  always_comb begin
    state_n = state;
    idx_n = tbl_idx;
    retry_n = retry_q;
    pwr_n = pwr_cnt;
    to_n = to_cnt;
    addr_n = addr_q;
    data_n = data_q;
    ph_n = ph;
    case (state)
      WAIT_PWR:
        if (pwr_cnt == 32'(PWR_WAIT - 1)) begin
          state_n = FETCH;
          pwr_n = '0;
          ph_n = 1'b0;
        end else pwr_n = pwr_cnt + 32'd1;
      FETCH:
        if (ph) begin
          {addr_n, data_n} = tbl_entry;
          ph_n = 1'b0;
          state_n = ISSUE;
        end else ph_n = 1'b1;
      ISSUE:
        if (!i2c.i2c_busy) begin
          to_n = '0;
          state_n = WAIT_DONE;
        end
      WAIT_DONE:
        if (to_cnt == 32'(TIMEOUT - 1)) state_n = ERROR;
        else if (i2c.i2c_done && !i2c.i2c_nack) state_n = NEXT;
`ifdef CODEC_CFG_RETRY_EN
        else if (i2c.i2c_done) begin
          state_n = retry_q == 2'd3 ? ERROR : ISSUE;
          retry_n = retry_q == 2'd3 ? retry_q : retry_q + 2'd1;
        end
`else
        else if (i2c.i2c_done) state_n = ERROR;
`endif
        else to_n = to_cnt + 32'd1;
      NEXT: begin
        retry_n = '0;
        state_n = tbl_idx == 8'(NUM_REGS - 1) ? DONE : FETCH;
        idx_n = tbl_idx == 8'(NUM_REGS - 1) ? tbl_idx : tbl_idx + 8'd1;
      end
      default:
        if (cfg_start) begin
          state_n = WAIT_PWR;
          idx_n = '0;
          retry_n = '0;
          pwr_n = '0;
        end
    endcase
  end
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= WAIT_PWR;
      tbl_idx <= '0;
      retry_q <= '0;
      pwr_cnt <= '0;
      to_cnt <= '0;
      addr_q <= '0;
      data_q <= '0;
      ph <= 1'b0;
    end else begin
      state <= state_n;
      tbl_idx <= idx_n;
      retry_q <= retry_n;
      pwr_cnt <= pwr_n;
      to_cnt <= to_n;
      addr_q <= addr_n;
      data_q <= data_n;
      ph <= ph_n;
    end
  end
  assign i2c.i2c_start = !reset && state == ISSUE && !i2c.i2c_busy;
  assign i2c.i2c_dev = DEV_ADDR;
  assign i2c.i2c_addr = reset ? '0 : addr_q;
  assign i2c.i2c_data = reset ? '0 : data_q;
  assign busy = reset || !(state == DONE || state == ERROR);
  assign cfg_done = !reset && state == DONE;
  assign error = !reset && state == ERROR;
  assign retry_cnt = reset ? '0 : retry_q;
endmodule

// File: doc/codec_cfg_sequencer.md
CODEC_CFG_SEQUENCER -- requirements
Module: codec_cfg_sequencer

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16, number of table entries written per configuration run (1..256).
REQ-002 SHALL have parameter DEV_ADDR, default 7'h3B, 7-bit I2C device address of the codec.
REQ-003 SHALL have parameter PWR_WAIT, default 1024, clock cycles waited after reset or cfg_start before the first write.
REQ-004 SHALL have parameter TIMEOUT, default 65535, maximum cycles in WAIT_DONE before an error is declared.
REQ-005 SHALL have these ports, one per line:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- cfg_start  input  1  single-cycle pulse; re-runs configuration from DONE or ERROR
- tbl_idx  output  8  table read index
- tbl_entry  input  24  {reg_addr[23:8], reg_data[7:0]}; valid one cycle after tbl_idx changes
- i2c_start  output  1  single-cycle write request to the I2C master
- i2c_dev  output  7  device address; equals DEV_ADDR
- i2c_addr  output  16  codec register address
- i2c_data  output  8  codec register data
- i2c_busy  input  1  I2C master busy
- i2c_done  input  1  single-cycle transaction-complete pulse
- i2c_nack  input  1  NACK flag, qualified by i2c_done
- busy  output  1  high in every state except DONE and ERROR
- cfg_done  output  1  high while in DONE
- error  output  1  high while in ERROR
- retry_cnt  output  2  retries used on the current entry

Function
REQ-006 SHALL implement the states WAIT_PWR, FETCH, ISSUE, WAIT_DONE, NEXT, DONE and ERROR.
REQ-007 SHALL remain in WAIT_PWR for exactly PWR_WAIT cycles, then go to FETCH.
REQ-008 SHALL spend exactly 2 cycles in FETCH with tbl_idx stable, and capture tbl_entry into i2c_addr/i2c_data on the second cycle.
REQ-009 SHALL, in ISSUE, wait while i2c_busy=1, then pulse i2c_start for 1 cycle once i2c_busy=0 and enter WAIT_DONE.
REQ-010 SHALL hold i2c_addr and i2c_data stable from the i2c_start pulse until i2c_done.
REQ-011 SHALL, in WAIT_DONE, go to NEXT on i2c_done with i2c_nack=0.
REQ-012 SHALL, on i2c_done with i2c_nack=1, follow REQ-024/REQ-025.
REQ-013 SHALL, in NEXT, clear retry_cnt and go to DONE if tbl_idx=NUM_REGS-1; otherwise it SHALL increment tbl_idx and go to FETCH.
REQ-014 SHALL count cycles in WAIT_DONE and go to ERROR when the count reaches TIMEOUT without i2c_done; the counter SHALL clear on entry to WAIT_DONE.
REQ-015 SHALL ignore i2c_done in any state other than WAIT_DONE.
REQ-016 SHALL ignore cfg_start while busy=1.
REQ-017 SHALL, on cfg_start in DONE or ERROR, clear tbl_idx and retry_cnt, deassert cfg_done and error, and enter WAIT_PWR.
REQ-018 SHALL hold i2c_start low in every cycle other than the single ISSUE exit cycle.
REQ-019 SHALL give precedence to the TIMEOUT check when i2c_done and the timeout occur in the same cycle.

Reset
REQ-020 SHALL, while reset=1, force the state to WAIT_PWR and clear tbl_idx, retry_cnt, the power-wait counter and the timeout counter.
REQ-021 SHALL drive these output values during reset: i2c_start=0, i2c_addr=0, i2c_data=0, cfg_done=0, error=0, busy=1.
REQ-022 SHALL abandon any in-flight transaction when reset is asserted mid-operation, with no further i2c_start until the full PWR_WAIT has elapsed.

Configuration
REQ-023 SHALL support the compile-time macro CODEC_CFG_RETRY_EN.
REQ-024 SHALL, with CODEC_CFG_RETRY_EN defined, on a NACK increment retry_cnt and return to ISSUE with the same entry while retry_cnt<3, and go to ERROR when a NACK occurs at retry_cnt=3.
REQ-025 SHALL, without CODEC_CFG_RETRY_EN, go directly to ERROR on any NACK and tie retry_cnt to 0.

Verification
REQ-026 SHALL pass this case: NUM_REGS=4, PWR_WAIT=16, model acks every transaction after 10 cycles -> 4 i2c_start pulses with addr/data matching table entries 0..3 in order, cfg_done=1, first i2c_start no earlier than cycle 16 after reset release.
REQ-027 SHALL pass this case: i2c_busy held high 50 cycles in ISSUE -> no i2c_start until the cycle after i2c_busy falls.
REQ-028 SHALL pass this case: with retry enabled, entry 2 NACKed twice then acked -> 3 pulses carrying entry 2 values, retry_cnt reaches 2, run completes with cfg_done=1; without the macro, the first NACK -> error=1 and tbl_idx=2.
REQ-029 SHALL pass this case: TIMEOUT=100, no i2c_done -> error=1 exactly 100 cycles after WAIT_DONE entry; a subsequent cfg_start -> WAIT_PWR then a full rerun from index 0.
REQ-030 SHALL pass this case: reset pulsed during WAIT_DONE of entry 1, then a stray i2c_done -> ignored, tbl_idx=0, outputs at reset values, restart after PWR_WAIT.
